// File: rtl/riscv_core_rf_param_if.sv
// riscv_core_rf_param_if: register-file port bundle (read/write/clear requests and read data)
interface riscv_core_rf_param_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            i_rf_clr;
  logic            i_rf_we3;
  logic [AW-1:0]   i_rf_a1;
  logic [AW-1:0]   i_rf_a2;
  logic [AW-1:0]   i_rf_a3;
  logic [XLEN-1:0] i_rf_wd3;
  logic [XLEN-1:0] o_rf_rd1;
  logic [XLEN-1:0] o_rf_rd2;
  logic            o_rf_ready;
  modport master (
    output i_rf_clr, i_rf_we3, i_rf_a1, i_rf_a2, i_rf_a3, i_rf_wd3,
    input  o_rf_rd1, o_rf_rd2, o_rf_ready
  );
  modport slave (
    input  i_rf_clr, i_rf_we3, i_rf_a1, i_rf_a2, i_rf_a3, i_rf_wd3,
    output o_rf_rd1, o_rf_rd2, o_rf_ready
  );
endinterface

// File: rtl/riscv_core_rf_param.sv
// riscv_core_rf_param: 2R1W register file with zero-fill sweep after reset/clear; x0 hardwired to 0.
// Optional same-cycle write-through to the read ports with RISCV_CORE_RF_BYPASS_EN.
module riscv_core_rf_param #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input logic                   i_rf_clk,
  input logic                   i_rf_rst,
  riscv_core_rf_param_if.slave  bus
);
  localparam int            NREG = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t          r_state, w_state_nx;
  logic [AW-1:0]   r_cnt, w_cnt_nx;
  logic [XLEN-1:0] r_rf [NREG];
  logic            w_ready, w_wr, w_byp1, w_byp2;
  always_ff @(posedge i_rf_clk or posedge i_rf_rst)
    if (i_rf_rst) begin
      r_state <= CLEAR;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == CLEAR) begin
      w_cnt_nx   = (bus.i_rf_clr || r_cnt == LAST) ? AW'(1) : r_cnt + AW'(1);
      w_state_nx = (!bus.i_rf_clr && r_cnt == LAST) ? READY : CLEAR;
    end else if (bus.i_rf_clr) begin
      w_state_nx = CLEAR;
      w_cnt_nx   = AW'(1);
    end
  end
  assign w_ready = (r_state == READY);
  assign w_wr    = w_ready && !bus.i_rf_clr && bus.i_rf_we3 && bus.i_rf_a3 != '0;
  // The sweep counter never reaches 0, so entry 0 is never written and reads are masked
  always_ff @(posedge i_rf_clk)
    if (r_state == CLEAR) r_rf[r_cnt] <= '0;
    else if (w_wr) r_rf[bus.i_rf_a3] <= bus.i_rf_wd3;
`ifdef RISCV_CORE_RF_BYPASS_EN
  assign w_byp1 = w_wr && bus.i_rf_a1 == bus.i_rf_a3;
  assign w_byp2 = w_wr && bus.i_rf_a2 == bus.i_rf_a3;
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif
  assign bus.o_rf_rd1   = (!w_ready || bus.i_rf_a1 == '0) ? '0 : w_byp1 ? bus.i_rf_wd3 : r_rf[bus.i_rf_a1];
  assign bus.o_rf_rd2   = (!w_ready || bus.i_rf_a2 == '0) ? '0 : w_byp2 ? bus.i_rf_wd3 : r_rf[bus.i_rf_a2];
  assign bus.o_rf_ready = w_ready;
endmodule

// File: tb/tb_riscv_core_rf_param.sv
// tb_riscv_core_rf_param: vector table with expected-value queue plus sweep/clear/reset sequences
module tb_riscv_core_rf_param;
  localparam int XLEN = 64;
  localparam int AW   = 5;
`ifdef RISCV_CORE_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic clr, we;
    logic [4:0] a1, a2, a3;
    logic [63:0] wd, e1, e2;
    logic er;
  } vec_t;
  typedef struct {
    logic [63:0] e1, e2;
    logic er;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  exp_t sbq[$];
  always #5 clk = ~clk;
  riscv_core_rf_param_if #(.XLEN(XLEN), .AW(AW)) bus();
  riscv_core_rf_param #(.XLEN(XLEN), .AW(AW)) dut (.i_rf_clk(clk), .i_rf_rst(rst), .bus(bus));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask
  task automatic drive(input logic clr, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [63:0] wd);
    bus.i_rf_clr = clr;
    bus.i_rf_we3 = we;
    bus.i_rf_a1  = a1;
    bus.i_rf_a2  = a2;
    bus.i_rf_a3  = a3;
    bus.i_rf_wd3 = wd;
  endtask
  // Called at a negedge just after the edge that starts the sweep; counts edges until ready
  task automatic wait_ready(input string nm);
    int n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.o_rf_ready) break;
      chk({nm, "_rd1_zero"}, bus.o_rf_rd1, 64'd0);
      chk({nm, "_rd2_zero"}, bus.o_rf_rd2, 64'd0);
    end
    chk(nm, 64'(n), 64'd31);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[11];
    exp_t e;
    v[0]  = '{1'b0, 1'b1, 5'd5,  5'd5,  5'd5,  64'hDEADBEEF_CAFEF00D,
              BYP ? 64'hDEADBEEF_CAFEF00D : 64'd0, BYP ? 64'hDEADBEEF_CAFEF00D : 64'd0, 1'b1};
    v[1]  = '{1'b0, 1'b0, 5'd5,  5'd5,  5'd0,  64'd0,
              64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b1};
    v[2]  = '{1'b0, 1'b1, 5'd0,  5'd5,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF,
              64'd0, 64'hDEADBEEF_CAFEF00D, 1'b1};
    v[3]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  64'd0, 64'd0, 64'd0, 1'b1};
    v[4]  = '{1'b0, 1'b1, 5'd7,  5'd5,  5'd7,  64'h1234,
              BYP ? 64'h1234 : 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b1};
    v[5]  = '{1'b0, 1'b0, 5'd7,  5'd7,  5'd0,  64'd0, 64'h1234, 64'h1234, 1'b1};
    v[6]  = '{1'b0, 1'b1, 5'd7,  5'd7,  5'd7,  64'hAAAA,
              BYP ? 64'hAAAA : 64'h1234, BYP ? 64'hAAAA : 64'h1234, 1'b1};
    v[7]  = '{1'b0, 1'b1, 5'd31, 5'd7,  5'd31, 64'h8000_0000_0000_0001,
              BYP ? 64'h8000_0000_0000_0001 : 64'd0, 64'hAAAA, 1'b1};
    v[8]  = '{1'b0, 1'b0, 5'd31, 5'd1,  5'd0,  64'd0, 64'h8000_0000_0000_0001, 64'd0, 1'b1};
    v[9]  = '{1'b0, 1'b1, 5'd5,  5'd1,  5'd1,  64'h11,
              64'hDEADBEEF_CAFEF00D, BYP ? 64'h11 : 64'd0, 1'b1};
    v[10] = '{1'b0, 1'b0, 5'd1,  5'd31, 5'd0,  64'd0, 64'h11, 64'h8000_0000_0000_0001, 1'b1};
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(bus.o_rf_ready), 64'd0);
    chk("reset_rd1", bus.o_rf_rd1, 64'd0);
    rst = 1'b0;
    wait_ready("sweep_after_reset");
    for (int i = 0; i < 11; i++) begin
      drive(v[i].clr, v[i].we, v[i].a1, v[i].a2, v[i].a3, v[i].wd);
      sbq.push_back('{v[i].e1, v[i].e2, v[i].er});
      #1;
      e = sbq.pop_front();
      chk($sformatf("vec%0d_rd1", i), bus.o_rf_rd1, e.e1);
      chk($sformatf("vec%0d_rd2", i), bus.o_rf_rd2, e.e2);
      chk($sformatf("vec%0d_ready", i), 64'(bus.o_rf_ready), 64'(e.er));
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 64'h99);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd3, 5'd5, 5'd3, 64'h55);
    #1;
    chk("clr_we_no_bypass", bus.o_rf_rd1, 64'h99);
    chk("clr_we_ready_before", 64'(bus.o_rf_ready), 64'd1);
    @(negedge clk);
    chk("clr_ready_drop", 64'(bus.o_rf_ready), 64'd0);
    drive(1'b0, 1'b0, 5'd3, 5'd5, 5'd0, 64'd0);
    wait_ready("clr_sweep_len");
    #1;
    chk("clr_write_dropped_x3", bus.o_rf_rd1, 64'd0);
    chk("sweep_cleared_x5", bus.o_rf_rd2, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd3, 5'd5, 5'd5, 64'h77);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd3, 5'd5, 5'd0, 64'd0);
    #1;
    chk("write_before_rst", bus.o_rf_rd2, 64'h77);
    rst = 1'b1;
    #1;
    chk("rst_async_ready", 64'(bus.o_rf_ready), 64'd0);
    chk("rst_async_rd2", bus.o_rf_rd2, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_sweep_not_ready", 64'(bus.o_rf_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("rst_mid_sweep");
    #1;
    chk("rst_sweep_cleared_x5", bus.o_rf_rd2, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    drive(1'b1, 1'b0, 5'd3, 5'd5, 5'd0, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd3, 5'd5, 5'd0, 64'd0);
    wait_ready("clr_in_clear");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
